driver_cntrl_mc: RTL and testbench

- Multi-channel successor to the single-channel driver control/status register block.
- Presents NUM_CH independent driver channels behind one slave register port. Each channel has:
  - a program state machine;
  - an address-FIFO push path;
  - a consecutive-address generator;
  - sticky error/interrupt logic;
  - a monitor-counter readout window.
- Sits between the AXI-lite slave adapter and the per-channel address/vector FIFOs and vector engines.

---
 rtl/driver_cntrl_mc.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_driver_cntrl_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/driver_cntrl_mc.sv
// driver_cntrl_mc: multi-channel driver control/status register block behind one slave port.
// Optional drain watchdog is built only when DRIVER_CNTRL_TIMEOUT_EN is defined.
module driver_cntrl_mc #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned MON_DEPTH       = 16,
    parameter int unsigned MON_CNT_W       = 16,
    parameter int unsigned DEF_ADDR_THRESH = 820,
    parameter int unsigned DEF_VCTR_THRESH = 7500,
    parameter int unsigned DRAIN_TIMEOUT   = 65535
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              slave_wr,
    input  logic [ADDR_W-1:0]                 slave_awaddr,
    input  logic [31:0]                       slave_data_in,
    input  logic                              slave_rd,
    input  logic [ADDR_W-1:0]                 slave_araddr,
    output logic [31:0]                       slave_data_out,
    output logic                              slave_rd_valid,
    output logic [NUM_CH*32-1:0]              addr_fifo_din,
    output logic [NUM_CH-1:0]                 addr_fifo_wr,
    input  logic [NUM_CH-1:0]                 addr_fifo_full,
    input  logic [NUM_CH-1:0]                 addr_fifo_empty,
    input  logic [NUM_CH-1:0]                 addr_fifo_overrun,
    input  logic [NUM_CH-1:0]                 addr_fifo_underrun,
    input  logic [NUM_CH-1:0]                 vector_fifo_empty,
    input  logic [NUM_CH-1:0]                 vector_fifo_overrun,
    input  logic [NUM_CH-1:0]                 vector_fifo_underrun,
    input  logic [NUM_CH*16-1:0]              words_in_addr_fifo,
    input  logic [NUM_CH*16-1:0]              words_in_vctr_fifo,
    input  logic [NUM_CH*MON_DEPTH*MON_CNT_W-1:0] mon_cnts,
    output logic [NUM_CH*16-1:0]              addr_fifo_threshold,
    output logic [NUM_CH*16-1:0]              vector_fifo_threshold,
    output logic [NUM_CH-1:0]                 run_program,
    output logic [NUM_CH-1:0]                 active_program,
    output logic                              irq
);
    localparam int unsigned PAGE_W = ADDR_W - 12;

    if (NUM_CH < 1 || NUM_CH > 8 || MON_CNT_W > 32 || DRAIN_TIMEOUT == 0) begin : g_param_check
        $error("driver_cntrl_mc: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_FREEZE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t      state_q  [NUM_CH];
    state_t      state_d  [NUM_CH];
    logic        freeze_q [NUM_CH];
    logic        freeze_d [NUM_CH];
    logic [15:0] athr_q   [NUM_CH];
    logic [15:0] athr_d   [NUM_CH];
    logic [15:0] vthr_q   [NUM_CH];
    logic [15:0] vthr_d   [NUM_CH];
    logic [6:0]  sticky_q [NUM_CH];
    logic [6:0]  sticky_d [NUM_CH];
    logic [6:0]  mask_q   [NUM_CH];
    logic [6:0]  mask_d   [NUM_CH];
    logic [31:0] base_q   [NUM_CH];
    logic [31:0] base_d   [NUM_CH];
    logic [31:0] gaddr_q  [NUM_CH];
    logic [31:0] gaddr_d  [NUM_CH];
    logic [7:0]  gcnt_q   [NUM_CH];
    logic [7:0]  gcnt_d   [NUM_CH];
    logic [31:0] fdin_d   [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d, fwr_d, irq_ch_c;
    logic [31:0] rdata_c;
`ifdef DRIVER_CNTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q [NUM_CH];
    logic [TMO_W-1:0] tmo_d [NUM_CH];
`endif

    logic [PAGE_W-1:0] wr_page, rd_page;
    logic [11:0]       wr_off, rd_off;
    assign wr_page = slave_awaddr[ADDR_W-1:12];
    assign wr_off  = slave_awaddr[11:0];
    assign rd_page = slave_araddr[ADDR_W-1:12];
    assign rd_off  = slave_araddr[11:0];

    // Per-channel next-state: register writes, generator, sticky bits and program FSM
    always_comb begin
        logic       sel, wr_ctrl, run_p, end_p, abort_p, consec_p, err, tmo_hit;
        logic [6:0] w1c, set;
        logic [3:0] sticky_lo;
        fwr_d  = '0;
        busy_d = busy_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            freeze_d[c] = freeze_q[c];
            athr_d[c]   = athr_q[c];
            vthr_d[c]   = vthr_q[c];
            mask_d[c]   = mask_q[c];
            base_d[c]   = base_q[c];
            gaddr_d[c]  = gaddr_q[c];
            gcnt_d[c]   = gcnt_q[c];
            fdin_d[c]   = addr_fifo_din[c*32 +: 32];

            sel      = slave_wr && (wr_page == PAGE_W'(c + 1));
            wr_ctrl  = sel && (wr_off == 12'h004);
            run_p    = wr_ctrl && slave_data_in[0];
            end_p    = wr_ctrl && slave_data_in[1];
            abort_p  = wr_ctrl && slave_data_in[2];
            consec_p = wr_ctrl && slave_data_in[7];
            w1c      = (sel && (wr_off == 12'h014)) ? slave_data_in[6:0] : 7'h00;
            set      = {3'b000, vector_fifo_underrun[c], vector_fifo_overrun[c],
                        addr_fifo_underrun[c], addr_fifo_overrun[c]};
            err      = |set[3:0];

            if (wr_ctrl)                      freeze_d[c] = slave_data_in[3];
            if (sel && wr_off == 12'h008)     athr_d[c]   = slave_data_in[15:0];
            if (sel && wr_off == 12'h00C)     vthr_d[c]   = slave_data_in[15:0];
            if (sel && wr_off == 12'h018)     mask_d[c]   = slave_data_in[6:0];
            if (sel && wr_off == 12'h01C)     base_d[c]   = slave_data_in;

            // Consecutive-address generator; abort kills it, including the push this cycle
            if (abort_p) begin
                busy_d[c] = 1'b0;
            end else if (busy_q[c]) begin
                if (!addr_fifo_full[c]) begin
                    fwr_d[c]   = 1'b1;
                    fdin_d[c]  = gaddr_q[c];
                    gaddr_d[c] = gaddr_q[c] + 32'd4;
                    gcnt_d[c]  = gcnt_q[c] - 8'd1;
                    if (gcnt_q[c] == 8'd1) busy_d[c] = 1'b0;
                end
            end else if (consec_p && slave_data_in[15:8] != 8'd0) begin
                busy_d[c]  = 1'b1;
                gaddr_d[c] = base_q[c];
                gcnt_d[c]  = slave_data_in[15:8];
            end

            if (sel && wr_off == 12'h000) begin
                if (busy_q[c]) begin
                    set[4] = 1'b1;
                end else begin
                    fwr_d[c]  = 1'b1;
                    fdin_d[c] = slave_data_in;
                end
            end

`ifdef DRIVER_CNTRL_TIMEOUT_EN
            tmo_d[c] = (state_q[c] == ST_DRAIN) ? tmo_q[c] + TMO_W'(1) : '0;
            tmo_hit  = (state_q[c] == ST_DRAIN) && (tmo_q[c] == TMO_W'(DRAIN_TIMEOUT - 1));
`else
            tmo_hit  = 1'b0;
`endif
            sticky_lo = (sticky_q[c][3:0] & ~w1c[3:0]) | set[3:0];

            // Priority: abort > error > end > freeze
            case (state_q[c])
                ST_IDLE: if (run_p) state_d[c] = ST_RUN;
                ST_RUN: begin
                    if (abort_p)       state_d[c] = ST_IDLE;
                    else if (err)      state_d[c] = ST_ERROR;
                    else if (end_p)    state_d[c] = ST_DRAIN;
                    else if (freeze_q[c]) state_d[c] = ST_FREEZE;
                end
                ST_FREEZE: begin
                    if (abort_p)       state_d[c] = ST_IDLE;
                    else if (end_p)    state_d[c] = ST_DRAIN;
                    else if (!freeze_q[c]) state_d[c] = ST_RUN;
                end
                ST_DRAIN: begin
                    if (abort_p) begin
                        state_d[c] = ST_IDLE;
                    end else if (err) begin
                        state_d[c] = ST_ERROR;
                    end else if (tmo_hit) begin
                        state_d[c] = ST_ERROR;
                        set[6]     = 1'b1;
                    end else if (addr_fifo_empty[c] && vector_fifo_empty[c]) begin
                        state_d[c] = ST_IDLE;
                        set[5]     = 1'b1;
                    end
                end
                ST_ERROR: if (sel && wr_off == 12'h014 && sticky_lo == 4'h0) state_d[c] = ST_IDLE;
                default: state_d[c] = ST_IDLE;
            endcase

            sticky_d[c] = (sticky_q[c] & ~w1c) | set;
        end
    end

    // Read mux; reads see register contents before any same-cycle write
    always_comb begin
        rdata_c = 32'h0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            irq_ch_c[c] = |(sticky_q[c] & mask_q[c]);
        end
        if (rd_page == PAGE_W'(0)) begin
            if (rd_off == 12'h000) rdata_c = {24'h0, 8'(NUM_CH)};
            if (rd_off == 12'h004) rdata_c = 32'(irq_ch_c);
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_page == PAGE_W'(c + 1)) begin
                case (rd_off)
                    12'h004: rdata_c = {28'h0, freeze_q[c], 3'b000};
                    12'h008: rdata_c = {16'h0, athr_q[c]};
                    12'h00C: rdata_c = {16'h0, vthr_q[c]};
                    12'h010: rdata_c = {28'h0, busy_q[c], state_q[c]};
                    12'h014: rdata_c = {25'h0, sticky_q[c]};
                    12'h018: rdata_c = {25'h0, mask_q[c]};
                    12'h01C: rdata_c = base_q[c];
                    12'h020: rdata_c = {16'h0, words_in_addr_fifo[c*16 +: 16]};
                    12'h024: rdata_c = {16'h0, words_in_vctr_fifo[c*16 +: 16]};
                    default: begin
                        for (int unsigned i = 0; i < MON_DEPTH; i++) begin
                            if (rd_off == 12'(256 + 4 * i))
                                rdata_c = 32'(mon_cnts[(c*MON_DEPTH + i)*MON_CNT_W +: MON_CNT_W]);
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            addr_fifo_threshold[c*16 +: 16]   = athr_q[c];
            vector_fifo_threshold[c*16 +: 16] = vthr_q[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= ST_IDLE;
                freeze_q[c] <= 1'b0;
                athr_q[c]   <= 16'(DEF_ADDR_THRESH);
                vthr_q[c]   <= 16'(DEF_VCTR_THRESH);
                sticky_q[c] <= '0;
                mask_q[c]   <= '0;
                base_q[c]   <= '0;
                gaddr_q[c]  <= '0;
                gcnt_q[c]   <= '0;
`ifdef DRIVER_CNTRL_TIMEOUT_EN
                tmo_q[c]    <= '0;
`endif
            end
            busy_q         <= '0;
            addr_fifo_wr   <= '0;
            addr_fifo_din  <= '0;
            run_program    <= '0;
            active_program <= '0;
            irq            <= 1'b0;
            slave_data_out <= '0;
            slave_rd_valid <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                freeze_q[c] <= freeze_d[c];
                athr_q[c]   <= athr_d[c];
                vthr_q[c]   <= vthr_d[c];
                sticky_q[c] <= sticky_d[c];
                mask_q[c]   <= mask_d[c];
                base_q[c]   <= base_d[c];
                gaddr_q[c]  <= gaddr_d[c];
                gcnt_q[c]   <= gcnt_d[c];
`ifdef DRIVER_CNTRL_TIMEOUT_EN
                tmo_q[c]    <= tmo_d[c];
`endif
                addr_fifo_din[c*32 +: 32] <= fdin_d[c];
                run_program[c]    <= (state_d[c] == ST_RUN);
                active_program[c] <= (state_d[c] == ST_RUN) || (state_d[c] == ST_FREEZE) ||
                                     (state_d[c] == ST_DRAIN);
            end
            busy_q         <= busy_d;
            addr_fifo_wr   <= fwr_d;
            irq            <= |irq_ch_c;
            slave_rd_valid <= slave_rd;
            if (slave_rd) slave_data_out <= rdata_c;
        end
    end
endmodule

// File: tb/tb_driver_cntrl_mc.sv
// tb_driver_cntrl_mc: directed self-checking bench for driver_cntrl_mc (NUM_CH=2).
module tb_driver_cntrl_mc;
    localparam int unsigned NCH = 2;
    localparam int unsigned MD  = 16;
    localparam int unsigned MW  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              slave_wr = 1'b0;
    logic [15:0]       slave_awaddr = '0;
    logic [31:0]       slave_data_in = '0;
    logic              slave_rd = 1'b0;
    logic [15:0]       slave_araddr = '0;
    logic [31:0]       slave_data_out;
    logic              slave_rd_valid;
    logic [NCH*32-1:0] addr_fifo_din;
    logic [NCH-1:0]    addr_fifo_wr;
    logic [NCH-1:0]    addr_fifo_full = '0;
    logic [NCH-1:0]    addr_fifo_empty = '1;
    logic [NCH-1:0]    addr_fifo_overrun = '0;
    logic [NCH-1:0]    addr_fifo_underrun = '0;
    logic [NCH-1:0]    vector_fifo_empty = '1;
    logic [NCH-1:0]    vector_fifo_overrun = '0;
    logic [NCH-1:0]    vector_fifo_underrun = '0;
    logic [NCH*16-1:0] words_in_addr_fifo = 32'h0007_0003;
    logic [NCH*16-1:0] words_in_vctr_fifo = 32'h0009_0005;
    logic [NCH*MD*MW-1:0] mon_cnts;
    logic [NCH*16-1:0] addr_fifo_threshold, vector_fifo_threshold;
    logic [NCH-1:0]    run_program, active_program;
    logic              irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] pushq[$];
    logic [31:0] rd;
    int          qsz;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NCH*MD; i++) mon_cnts[i*MW +: MW] = 16'(16'hA000 + i);
    end

    driver_cntrl_mc #(.NUM_CH(NCH), .ADDR_W(16), .MON_DEPTH(MD), .MON_CNT_W(MW),
                      .DEF_ADDR_THRESH(820), .DEF_VCTR_THRESH(7500), .DRAIN_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .slave_wr(slave_wr), .slave_awaddr(slave_awaddr), .slave_data_in(slave_data_in),
        .slave_rd(slave_rd), .slave_araddr(slave_araddr),
        .slave_data_out(slave_data_out), .slave_rd_valid(slave_rd_valid),
        .addr_fifo_din(addr_fifo_din), .addr_fifo_wr(addr_fifo_wr),
        .addr_fifo_full(addr_fifo_full), .addr_fifo_empty(addr_fifo_empty),
        .addr_fifo_overrun(addr_fifo_overrun), .addr_fifo_underrun(addr_fifo_underrun),
        .vector_fifo_empty(vector_fifo_empty), .vector_fifo_overrun(vector_fifo_overrun),
        .vector_fifo_underrun(vector_fifo_underrun),
        .words_in_addr_fifo(words_in_addr_fifo), .words_in_vctr_fifo(words_in_vctr_fifo),
        .mon_cnts(mon_cnts),
        .addr_fifo_threshold(addr_fifo_threshold), .vector_fifo_threshold(vector_fifo_threshold),
        .run_program(run_program), .active_program(active_program), .irq(irq)
    );

    // Capture every ch0 push exactly once (wr is a one-cycle registered pulse)
    always @(negedge clk) if (!reset && addr_fifo_wr[0]) pushq.push_back(addr_fifo_din[31:0]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_wr = 1'b1; slave_awaddr = a; slave_data_in = d;
        @(negedge clk);
        slave_wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_rd = 1'b1; slave_araddr = a;
        @(negedge clk);
        slave_rd = 1'b0;
        d = slave_data_out;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // 1: reset values, ID register, read/write same-cycle ordering
        cycles(2);
        check("rst_athr", addr_fifo_threshold, {16'd820, 16'd820});
        check("rst_vthr", vector_fifo_threshold, {16'd7500, 16'd7500});
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_run", 32'(run_program), 32'h0);
        check("rst_wr", 32'(addr_fifo_wr), 32'h0);
        reset = 1'b0;
        reg_rd(16'h0000, rd);
        check("id_reg", rd, 32'h0000_0002);
        check("rd_valid", 32'(slave_rd_valid), 32'h1);
        reg_rd(16'h1010, rd);
        check("rst_status0", rd, 32'h0);
        reg_rd(16'h2024, rd);
        check("words_vctr1", rd, 32'h0000_0009);
        reg_rd(16'h2100 + 16'h0c, rd);
        check("mon_ch1_3", rd, 32'h0000_A013);
        reg_rd(16'h1000 + 16'h0140, rd);
        check("mon_out_range", rd, 32'h0);
        @(negedge clk);
        slave_wr = 1'b1; slave_awaddr = 16'h1008; slave_data_in = 32'h123;
        slave_rd = 1'b1; slave_araddr = 16'h1008;
        @(negedge clk);
        slave_wr = 1'b0; slave_rd = 1'b0;
        check("rd_pre_write", slave_data_out, 32'd820);
        reg_rd(16'h1008, rd);
        check("rd_post_write", rd, 32'h123);

        // 2: ch1 run / end / drain completion, done interrupt
        reg_wr(16'h2004, 32'h1);
        check("ch1_run", 32'(run_program), 32'h2);
        check("ch1_active", 32'(active_program), 32'h2);
        reg_wr(16'h2018, 32'h20);
        vector_fifo_empty[1] = 1'b0;
        reg_wr(16'h2004, 32'h2);
        cycles(5);
        check("ch1_drain_hold", {30'h0, run_program[1], active_program[1]}, 32'h1);
        vector_fifo_empty[1] = 1'b1;
        cycles(2);
        check("ch1_idle", 32'(active_program), 32'h0);
        check("ch1_done_irq", 32'(irq), 32'h1);
        reg_rd(16'h2014, rd);
        check("ch1_sticky_done", rd, 32'h20);
        reg_rd(16'h0004, rd);
        check("irq_vector", rd, 32'h2);
        reg_wr(16'h2014, 32'h20);
        cycles(1);
        check("ch1_irq_clr", 32'(irq), 32'h0);

        // 3: ch0 consec burst wrapping past 2^32 with a full stall and a colliding write
        reg_wr(16'h101C, 32'hFFFF_FFF8);
        pushq.delete();
        reg_wr(16'h1004, 32'h0000_0480);
        cycles(1);
        addr_fifo_full[0] = 1'b1;
        reg_wr(16'h1000, 32'hDEAD_BEEF);
        cycles(1);
        addr_fifo_full[0] = 1'b0;
        cycles(8);
        qsz = pushq.size();
        check("burst_count", 32'(qsz), 32'd4);
        if (qsz == 4) begin
            check("burst_w0", pushq[0], 32'hFFFF_FFF8);
            check("burst_w1", pushq[1], 32'hFFFF_FFFC);
            check("burst_w2", pushq[2], 32'h0000_0000);
            check("burst_w3", pushq[3], 32'h0000_0004);
        end
        reg_rd(16'h1014, rd);
        check("collision_sticky", rd, 32'h10);
        reg_wr(16'h1014, 32'h10);
        pushq.delete();
        reg_wr(16'h1004, 32'h0000_0000 | 32'h80);
        reg_wr(16'h1000, 32'h0000_00AB);
        cycles(2);
        check("consec_n0_direct", (pushq.size() == 1) ? pushq[0] : 32'hFFFF_FFFF, 32'hAB);

        // 4: vector underrun in RUN -> ERROR, run ignored, W1C returns to IDLE
        reg_wr(16'h1004, 32'h1);
        check("ch0_run", 32'(run_program), 32'h1);
        @(negedge clk); vector_fifo_underrun[0] = 1'b1;
        @(negedge clk); vector_fifo_underrun[0] = 1'b0;
        reg_rd(16'h1010, rd);
        check("err_state", rd, 32'h4);
        reg_rd(16'h1014, rd);
        check("err_sticky", rd, 32'h08);
        reg_wr(16'h1004, 32'h1);
        reg_rd(16'h1010, rd);
        check("err_run_ignored", rd, 32'h4);
        reg_wr(16'h1014, 32'h08);
        reg_rd(16'h1010, rd);
        check("err_cleared", rd, 32'h0);

        // 5: abort in FREEZE with busy generator; async reset mid-burst
        reg_wr(16'h1008, 32'h55);
        reg_wr(16'h1004, 32'h1);
        reg_wr(16'h1004, 32'h8);
        reg_wr(16'h101C, 32'h0000_2000);
        reg_wr(16'h1004, 32'h0000_C888);
        cycles(3);
        reg_rd(16'h1010, rd);
        check("freeze_busy", rd, 32'hA);
        reg_wr(16'h1004, 32'h4);
        check("abort_idle", 32'(active_program), 32'h0);
        check("abort_wr_stop", 32'(addr_fifo_wr), 32'h0);
        qsz = pushq.size();
        cycles(5);
        check("abort_no_push", 32'(pushq.size()), 32'(qsz));
        reg_wr(16'h1004, 32'h0000_6480);
        cycles(3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_wr", 32'(addr_fifo_wr), 32'h0);
        check("async_rst_din", addr_fifo_din[31:0], 32'h0);
        check("async_rst_athr", 32'(addr_fifo_threshold[15:0]), 32'd820);
        @(negedge clk);
        reset = 1'b0;

        // 6: drain watchdog
        reg_wr(16'h1004, 32'h1);
        vector_fifo_empty[0] = 1'b0;
        reg_wr(16'h1004, 32'h2);
`ifdef DRIVER_CNTRL_TIMEOUT_EN
        cycles(15);
        check("tmo_still_drain", 32'(active_program[0]), 32'h1);
        cycles(1);
        check("tmo_left_drain", 32'(active_program[0]), 32'h0);
        reg_rd(16'h1014, rd);
        check("tmo_sticky", rd, 32'h40);
        reg_rd(16'h1010, rd);
        check("tmo_error", rd, 32'h4);
        reg_wr(16'h1014, 32'h40);
`else
        cycles(40);
        check("no_tmo_drain", 32'(active_program[0]), 32'h1);
        reg_rd(16'h1014, rd);
        check("no_tmo_sticky", rd, 32'h0);
        reg_wr(16'h1004, 32'h4);
`endif
        vector_fifo_empty[0] = 1'b1;
        reg_rd(16'h1010, rd);
        check("final_idle", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
